// File: rtl/delay_change_capture.sv
// Change-event capture: every edge where io_in differs from its previous sample
// pushes {io_in, timestamp} into a small FIFO; full-FIFO losses are counted.
module delay_change_capture #(
   parameter int DEPTH   = 4,
   parameter int STAMP_W = 16,
   parameter int DROP_W  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              io_in,
   input  logic                     io_clear,
   input  logic                     io_out_ready,
   output logic                     io_out_valid,
   output logic [31:0]              io_out_bits,
   output logic [STAMP_W-1:0]       io_out_stamp,
   output logic [$clog2(DEPTH):0]   io_count,
   output logic                     io_overflow,
   output logic [DROP_W-1:0]        io_drop_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = 32 + STAMP_W;

   logic [STAMP_W-1:0] stamp_q, stamp_d;
   logic [31:0]        prev_q, prev_d;
   logic               primed_q, primed_d;
   logic [EW-1:0]      mem_q [DEPTH];
   logic [EW-1:0]      mem_d [DEPTH];
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic               out_valid_q, out_valid_d;
   logic [31:0]        out_bits_q, out_bits_d;
   logic [STAMP_W-1:0] out_stamp_q, out_stamp_d;
   logic               overflow_q, overflow_d;
   logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;

   logic               push_s;
   logic               pop_s;
   logic               full_s;
   logic               accept_s;
   logic               drop_s;
   logic [CW-1:0]      remain_s;
   logic [EW-1:0]      head_s;

   // Next-state logic: change detection, FIFO bookkeeping, registered head and drop status
   always_comb begin
      stamp_d  = stamp_q + STAMP_W'(1'b1);
      prev_d   = io_in;
      primed_d = 1'b1;

      push_s   = primed_q && (io_in != prev_q);
      pop_s    = out_valid_q && io_out_ready;
      full_s   = (count_q == CW'(DEPTH));
      accept_s = push_s && (!full_s || pop_s);
      drop_s   = push_s && full_s && !pop_s;

      mem_d = mem_q;
      if (accept_s) begin
         mem_d[wr_ptr_q] = {io_in, stamp_q};
         wr_ptr_d        = wr_ptr_q + PW'(1'b1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1'b1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      remain_s = count_q - CW'(pop_s);
      count_d  = remain_s + CW'(accept_s);

      // When nothing survives the pop, the new head can only be the entry written this edge.
      if (remain_s == {CW{1'b0}}) begin
         head_s = {io_in, stamp_q};
      end else begin
         head_s = mem_q[rd_ptr_d];
      end

      out_valid_d = (count_d != {CW{1'b0}});
      if (out_valid_d) begin
         out_bits_d  = head_s[EW-1:STAMP_W];
         out_stamp_d = head_s[STAMP_W-1:0];
      end else begin
         out_bits_d  = out_bits_q;
         out_stamp_d = out_stamp_q;
      end

      if (io_clear) begin
         overflow_d = 1'b0;
         drop_cnt_d = {DROP_W{1'b0}};
      end else begin
         overflow_d = overflow_q;
         drop_cnt_d = drop_cnt_q;
      end
      if (drop_s) begin
         overflow_d = 1'b1;
         if (drop_cnt_d != {DROP_W{1'b1}}) begin
            drop_cnt_d = drop_cnt_d + DROP_W'(1'b1);
         end else begin
            drop_cnt_d = drop_cnt_d;
         end
      end else begin
         overflow_d = overflow_d;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stamp_q     <= {STAMP_W{1'b0}};
         prev_q      <= 32'd0;
         primed_q    <= 1'b0;
         mem_q       <= '{default: {EW{1'b0}}};
         wr_ptr_q    <= {PW{1'b0}};
         rd_ptr_q    <= {PW{1'b0}};
         count_q     <= {CW{1'b0}};
         out_valid_q <= 1'b0;
         out_bits_q  <= 32'd0;
         out_stamp_q <= {STAMP_W{1'b0}};
         overflow_q  <= 1'b0;
         drop_cnt_q  <= {DROP_W{1'b0}};
      end else begin
         stamp_q     <= stamp_d;
         prev_q      <= prev_d;
         primed_q    <= primed_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_bits_q  <= out_bits_d;
         out_stamp_q <= out_stamp_d;
         overflow_q  <= overflow_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign io_out_valid  = out_valid_q;
   assign io_out_bits   = out_bits_q;
   assign io_out_stamp  = out_stamp_q;
   assign io_count      = count_q;
   assign io_overflow   = overflow_q;
   assign io_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_delay_change_capture.sv
// Bench for delay_change_capture: directed scenarios plus random traffic, all
// outputs compared each cycle against a queue-based reference model.
module tb_delay_change_capture;

   localparam int DEPTH = 4;

   logic        clk;
   logic        reset;
   logic [31:0] io_in;
   logic        io_clear;
   logic        io_out_ready;
   logic        io_out_valid;
   logic [31:0] io_out_bits;
   logic [15:0] io_out_stamp;
   logic [2:0]  io_count;
   logic        io_overflow;
   logic [7:0]  io_drop_count;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   // reference model state
   logic [47:0] q[$];
   int          m_stamp;
   logic [31:0] m_prev;
   bit          m_primed;
   bit          m_ovf;
   int          m_dc;
   logic [31:0] m_bits;
   logic [15:0] m_hs;

   delay_change_capture #(.DEPTH(4), .STAMP_W(16), .DROP_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .io_in        (io_in),
      .io_clear     (io_clear),
      .io_out_ready (io_out_ready),
      .io_out_valid (io_out_valid),
      .io_out_bits  (io_out_bits),
      .io_out_stamp (io_out_stamp),
      .io_count     (io_count),
      .io_overflow  (io_overflow),
      .io_drop_count(io_drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_stamp  = 0;
      m_prev   = 32'd0;
      m_primed = 1'b0;
      m_ovf    = 1'b0;
      m_dc     = 0;
      m_bits   = 32'd0;
      m_hs     = 16'd0;
   endtask

   task automatic model_edge(input logic [31:0] in_v, input bit rdy, input bit clr);
      bit ev;
      bit drop;
      ev   = m_primed && (in_v != m_prev);
      drop = 1'b0;
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (ev) begin
         if (q.size() < DEPTH) q.push_back({in_v, 16'(m_stamp)});
         else drop = 1'b1;
      end
      if (clr) begin
         m_ovf = 1'b0;
         m_dc  = 0;
      end
      if (drop) begin
         m_ovf = 1'b1;
         if (m_dc < 255) m_dc++;
      end
      if (q.size() > 0) begin
         m_bits = q[0][47:16];
         m_hs   = q[0][15:0];
      end
      m_prev   = in_v;
      m_primed = 1'b1;
      m_stamp  = (m_stamp + 1) % 65536;
   endtask

   task automatic compare_all();
      check("valid",    64'(io_out_valid),  64'(q.size() > 0));
      check("count",    64'(io_count),      64'(q.size()));
      check("bits",     64'(io_out_bits),   64'(m_bits));
      check("stamp",    64'(io_out_stamp),  64'(m_hs));
      check("overflow", 64'(io_overflow),   64'(m_ovf));
      check("drops",    64'(io_drop_count), 64'(m_dc));
   endtask

   task automatic step(input logic [31:0] in_v, input bit rdy, input bit clr);
      @(negedge clk);
      io_in        = in_v;
      io_out_ready = rdy;
      io_clear     = clr;
      @(posedge clk);
      model_edge(in_v, rdy, clr);
      #1;
      compare_all();
   endtask

   // Holds reset over two edges, checks the reset state, releases just after a rising edge.
   task automatic do_reset(input logic [31:0] in_v);
      io_in        = in_v;
      io_out_ready = 1'b0;
      io_clear     = 1'b0;
      reset        = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      compare_all();
      #1;
      reset = 1'b1;
   endtask

   initial begin
      logic [31:0] cur;
      do_reset(32'd5);

      // Baseline: constant input never produces an event
      for (int i = 0; i < 10; i++) begin
         step(32'd5, (i % 2) == 1, 1'b0);
         check("base_valid", 64'(io_out_valid), 64'd0);
      end

      // Single change at stamp 3, consumer ready
      do_reset(32'd0);
      for (int i = 0; i < 3; i++) step(32'd0, 1'b1, 1'b0);
      step(32'd1, 1'b1, 1'b0);
      check("single_valid", 64'(io_out_valid), 64'd1);
      check("single_bits",  64'(io_out_bits),  64'd1);
      check("single_stamp", 64'(io_out_stamp), 64'd3);
      step(32'd1, 1'b1, 1'b0);
      check("single_popped", 64'(io_count), 64'd0);

      // Toggle stream with consumer stalled: 8 events, 4 kept, 4 dropped
      do_reset(32'd0);
      step(32'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 8; i++) step(32'(i % 2), 1'b0, 1'b0);
      check("tog_count", 64'(io_count),      64'd4);
      check("tog_ovf",   64'(io_overflow),   64'd1);
      check("tog_drops", 64'(io_drop_count), 64'd4);
      check("tog_bits",  64'(io_out_bits),   64'd1);
      check("tog_stamp", 64'(io_out_stamp),  64'd1);

      // Full FIFO with pop on the event edge: accepted, no drop, new entry last
      step(32'd1, 1'b1, 1'b0);
      check("fullpop_count", 64'(io_count),      64'd4);
      check("fullpop_drops", 64'(io_drop_count), 64'd4);
      check("fullpop_head",  64'(io_out_stamp),  64'd2);
      for (int i = 0; i < 3; i++) step(32'd1, 1'b1, 1'b0);
      check("fullpop_last", 64'(io_out_stamp), 64'd9);
      step(32'd1, 1'b1, 1'b0);
      check("drained_valid", 64'(io_out_valid), 64'd0);
      check("drained_hold",  64'(io_out_stamp), 64'd9);

      // Clear on the same edge as a drop
      step(32'd0, 1'b0, 1'b0);
      step(32'd1, 1'b0, 1'b0);
      step(32'd0, 1'b0, 1'b0);
      step(32'd1, 1'b0, 1'b0);
      step(32'd0, 1'b0, 1'b1);
      check("clr_ovf",   64'(io_overflow),   64'd1);
      check("clr_drops", 64'(io_drop_count), 64'd1);
      step(32'd0, 1'b0, 1'b1);
      check("clr_only",  64'(io_overflow),   64'd0);
      check("clr_keeps", 64'(io_count),      64'd4);

      // Drop counter saturation
      for (int i = 0; i < 260; i++) step(32'(i % 2), 1'b0, 1'b0);
      check("sat_drops", 64'(io_drop_count), 64'd255);

      // Reset in the middle of a stream holding 3 entries
      do_reset(32'd0);
      step(32'd0, 1'b0, 1'b0);
      step(32'd1, 1'b0, 1'b0);
      step(32'd2, 1'b0, 1'b0);
      step(32'd3, 1'b0, 1'b0);
      check("mid_count", 64'(io_count), 64'd3);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      compare_all();
      check("mid_async_valid", 64'(io_out_valid), 64'd0);
      do_reset(32'd7);
      step(32'd7, 1'b1, 1'b0);
      check("rel_no_event", 64'(io_out_valid), 64'd0);
      step(32'd7, 1'b1, 1'b0);
      check("rel_count", 64'(io_count), 64'd0);

      // Random traffic
      cur = 32'd0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 1) == 1) cur = 32'($urandom_range(0, 3));
         step(cur, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/delay_change_capture.md
DELAY_CHANGE_CAPTURE -- requirements
Module: delay_change_capture

Interface
REQ-001 Parameters SHALL be:
- DEPTH, 4, FIFO entries (power of two, >=2).
- STAMP_W, 16, timestamp width.
- DROP_W, 8, drop-counter width.

REQ-002 Ports SHALL be:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- io_in  input  32  sampled counter value from upstream stage.
- io_clear  input  1  synchronous clear of overflow and drop count.
- io_out_ready  input  1  consumer ready.
- io_out_valid  output  1  FIFO head valid.
- io_out_bits  output  32  captured value at FIFO head.
- io_out_stamp  output  STAMP_W  timestamp at FIFO head.
- io_count  output  log2(DEPTH)+1  FIFO occupancy.
- io_overflow  output  1  sticky: at least one event dropped.
- io_drop_count  output  DROP_W  dropped events, saturating.

REQ-003 Reset SHALL be asynchronous and active-low (reset=0 asserts); all other inputs SHALL be sampled only on the rising edge of clk.

Function
REQ-004 A free-running STAMP_W-bit counter SHALL increment every cycle and wrap from all-ones to 0.
REQ-005 The block SHALL register io_in every cycle into prev.
REQ-006 The first clock edge after reset deassertion SHALL only load prev and set primed=1; it SHALL NOT generate an event.
REQ-007 An event SHALL occur on any edge where primed=1 and io_in != prev.
- Any bit difference counts.
- Wrap-around of io_in (for example 1 -> 0) counts as a change.
REQ-008 An event SHALL attempt to push {io_in, current stamp} into the FIFO on the same edge.
REQ-009 The head entry SHALL appear on io_out_valid/io_out_bits/io_out_stamp one cycle after the push edge (latency 1).
REQ-010 Outputs SHALL be driven only from registers, with no combinational path from any input.
REQ-011 A pop SHALL occur on an edge where io_out_valid=1 and io_out_ready=1. io_out_bits and io_out_stamp SHALL hold stable while io_out_valid=1 and io_out_ready=0.
REQ-012 When io_count=0, io_out_valid SHALL be 0 and io_out_bits/io_out_stamp SHALL hold their last values.
REQ-013 Push to an empty FIFO with io_out_ready=1 SHALL NOT bypass: the entry becomes valid next cycle.
REQ-014 Full FIFO with push and no pop in the same edge: the event SHALL be dropped, io_overflow set to 1, and io_drop_count incremented.
REQ-015 Full FIFO with push and pop in the same edge: the push SHALL be accepted and io_count SHALL remain DEPTH.
REQ-016 Push and pop in the same edge at any other occupancy SHALL leave io_count unchanged.
REQ-017 io_drop_count SHALL saturate at all-ones and never wrap.
REQ-018 io_clear=1 SHALL zero io_overflow and io_drop_count at that edge.
- If a drop occurs on the same edge, the result SHALL be io_overflow=1 and io_drop_count=1.
- io_clear SHALL NOT affect FIFO contents.
REQ-019 Read and write pointers SHALL wrap modulo DEPTH; io_count SHALL be exact in 0..DEPTH.

Reset
REQ-020 While reset=0, the block SHALL hold:
- io_out_valid=0, io_out_bits=0, io_out_stamp=0
- io_count=0, io_overflow=0, io_drop_count=0
- stamp=0, prev=0, primed=0
REQ-021 Assertion of reset mid-operation SHALL immediately discard all FIFO contents and pending events.
REQ-022 After reset deassertion, the rules of REQ-006 SHALL apply again.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Baseline: release reset with io_in=5 held constant for 10 cycles -> no event, io_out_valid=0 throughout.
- Single change, ready=1: io_in 0 -> 1 at stamp 3 -> next cycle io_out_valid=1, bits=1, stamp=3; popped; io_count returns to 0.
- Toggle stream (upstream 1-bit counter alternating 0/1, zero-extended) with ready=0 for 8 cycles -> first 4 events stored with consecutive stamps, io_overflow=1, io_drop_count=3 or 4 per count of change edges; head holds first event.
- Full plus simultaneous pop: FIFO full, ready=1 during an event -> io_count stays 4, no drop, new entry is last.
- Clear collision: io_clear=1 on the same edge as a drop -> io_overflow=1, io_drop_count=1.
- Reset mid-stream: FIFO holding 3 entries, pulse reset=0 between clock edges -> outputs zero immediately; after release, first edge is baseline only.
